// File: rtl/pipelined_addsub_pkg.sv
// Shared arithmetic definitions for the pipelined adder/subtractor:
// operation encodings and the per-stage chunk width helper.
package pipelined_addsub_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/pipelined_addsub_adder_chunk.sv
// Combinational N-bit adder slice: sum, carry out, and the carry into the
// slice MSB (used by the last stage to derive signed overflow).
module adder_chunk
  import pipelined_addsub_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co,
  output logic         c_msb
);

  logic [N:0] total;

  assign total = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, ci};
  assign s     = total[N-1:0];
  assign co    = total[N];

  // The MSB sum bit is x ^ y ^ carry-in, so the carry-in falls out of it.
  assign c_msb = s[N-1] ^ x[N-1] ^ y[N-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Carry-pipelined adder/subtractor: one CHUNK-bit slice per stage, operands
// and partial results travel in skew registers, whole pipe freezes on stall.
module pipelined_addsub
  import pipelined_addsub_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);

  // Stage k output registers.
  logic [WIDTH-1:0]  a_reg   [STAGES];
  logic [WIDTH-1:0]  b_reg   [STAGES];
  logic [WIDTH-1:0]  res_reg [STAGES];
  logic [STAGES-1:0] carry_reg;
  logic [STAGES-1:0] valid_reg;
  logic              ovf_reg;
  logic              zero_reg;

  // Stage k inputs and combinational results.
  logic [WIDTH-1:0]  a_in    [STAGES];
  logic [WIDTH-1:0]  b_in    [STAGES];
  logic [WIDTH-1:0]  res_in  [STAGES];
  logic [WIDTH-1:0]  res_out [STAGES];
  logic [STAGES-1:0] c_in;
  logic [STAGES-1:0] v_in;
  logic [STAGES-1:0] co_w;
  logic [CHUNK-1:0]  s_w     [STAGES];
  logic              cm_w    [STAGES];

  logic stall;

  assign stall    = valid_reg[STAGES-1] && !out_ready;
  assign in_ready = !stall;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      // Subtraction is a + ~b + 1; the +1 rides in on the first carry.
      assign a_in[0]   = a;
      assign b_in[0]   = (op == OP_SUB) ? ~b : b;
      assign c_in[0]   = (op == OP_SUB) ? 1'b1 : cin;
      assign v_in[0]   = in_valid;
      assign res_in[0] = '0;
    end else begin : g_next
      assign a_in[k]   = a_reg[k-1];
      assign b_in[k]   = b_reg[k-1];
      assign c_in[k]   = carry_reg[k-1];
      assign v_in[k]   = valid_reg[k-1];
      assign res_in[k] = res_reg[k-1];
    end

    adder_chunk #(
      .N(CHUNK)
    ) u_chunk (
      .x     (a_in[k][k*CHUNK +: CHUNK]),
      .y     (b_in[k][k*CHUNK +: CHUNK]),
      .ci    (c_in[k]),
      .s     (s_w[k]),
      .co    (co_w[k]),
      .c_msb (cm_w[k])
    );

    // Chunks at and above k are still zero in res_in, so OR-ing merges cleanly.
    assign res_out[k] = res_in[k] | (WIDTH'(s_w[k]) << (k * CHUNK));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= '0;
      carry_reg <= '0;
      ovf_reg   <= 1'b0;
      zero_reg  <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        res_reg[k] <= '0;
      end
    end else if (!stall) begin
      for (int k = 0; k < STAGES; k++) begin
        a_reg[k]   <= a_in[k];
        b_reg[k]   <= b_in[k];
        res_reg[k] <= res_out[k];
      end
      carry_reg <= co_w;
      valid_reg <= v_in;
      ovf_reg   <= co_w[STAGES-1] ^ cm_w[STAGES-1];
      zero_reg  <= (res_out[STAGES-1] == '0);
    end
  end

  assign out_valid = valid_reg[STAGES-1];
  assign sum       = res_reg[STAGES-1];
  assign cout      = carry_reg[STAGES-1];
  assign overflow  = ovf_reg;
  assign zero      = zero_reg;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub: directed vector table, random
// streams, backpressure and mid-flight reset against a plain-arithmetic model.
module tb_pipelined_addsub;
  import pipelined_addsub_pkg::*;

  localparam int WIDTH  = 64;
  localparam int STAGES = 4;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
  } res_t;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             op;
    logic             cin;
    res_t             exp;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             op;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             zero;

  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];
  logic prev_stall = 1'b0;
  res_t prev_res;

  pipelined_addsub #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  // Reference: unsigned arithmetic for sum/cout, signed range test for overflow.
  function automatic res_t ref_model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                     input logic opv, input logic civ);
    res_t             r;
    logic [WIDTH:0]   u;
    logic signed [WIDTH+1:0] sa, sb, sr;
    sa = $signed({{2{av[WIDTH-1]}}, av});
    sb = $signed({{2{bv[WIDTH-1]}}, bv});
    if (opv) begin
      u      = {1'b0, av} - {1'b0, bv};
      r.cout = (av >= bv);
      sr     = sa - sb;
    end else begin
      u      = {1'b0, av} + {1'b0, bv} + {{WIDTH{1'b0}}, civ};
      r.cout = u[WIDTH];
      sr     = sa + sb + $signed({{(WIDTH+1){1'b0}}, civ});
    end
    r.sum  = u[WIDTH-1:0];
    r.zero = (r.sum == '0);
    r.ovf  = (sr > $signed({2'b00, 1'b0, {(WIDTH-1){1'b1}}})) ||
             (sr < $signed({2'b11, 1'b1, {(WIDTH-1){1'b0}}}));
    return r;
  endfunction

  function automatic res_t cur_res();
    return {sum, cout, overflow, zero};
  endfunction

  function automatic logic [WIDTH-1:0] rand64();
    case ($urandom_range(0, 5))
      0:       return '1;
      1:       return '0;
      2:       return {1'b1, {(WIDTH-1){1'b0}}};
      3:       return {1'b0, {(WIDTH-1){1'b1}}};
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  function automatic vec_t mk(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                              input logic opv, input logic civ, input logic [WIDTH-1:0] s,
                              input logic co, input logic ov, input logic z);
    vec_t v;
    v.a   = av;
    v.b   = bv;
    v.op  = opv;
    v.cin = civ;
    v.exp = {s, co, ov, z};
    return v;
  endfunction

  task automatic compare_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, got, want);
    end
  endtask

  task automatic compare_res(input string name, input res_t got, input res_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got sum=%h cout=%b ovf=%b zero=%b expected sum=%h cout=%b ovf=%b zero=%b",
               name, got.sum, got.cout, got.ovf, got.zero, want.sum, want.cout, want.ovf, want.zero);
    end
  endtask

  task automatic compare_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Scoreboard: accepted inputs go through the model, delivered results pop it.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      compare_bit("in_ready_rule", in_ready, !(out_valid && !out_ready));
      if (prev_stall) begin
        compare_bit("stall_valid_hold", out_valid, 1'b1);
        compare_res("stall_result_hold", cur_res(), prev_res);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          compare_int("spurious_result", 1, 0);
        end else begin
          compare_res("scoreboard_result", cur_res(), exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_model(a, b, op, cin));
      end
      prev_stall = out_valid && !out_ready;
      prev_res   = cur_res();
    end
  end

  task automatic apply_stimulus(input vec_t v, output int lat);
    a        = v.a;
    b        = v.b;
    op       = v.op;
    cin      = v.cin;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat      = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_output(input string tag, input vec_t v, input int lat);
    compare_int({tag, "_latency"}, lat, STAGES);
    compare_bit({tag, "_valid"}, out_valid, 1'b1);
    compare_res({tag, "_result"}, cur_res(), v.exp);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[10];
    vec_t v;
    int   lat;
    logic took;

    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    op        = 1'b0;
    cin       = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    compare_bit("reset_out_valid", out_valid, 1'b0);
    compare_res("reset_outputs", cur_res(), '0);
    rst = 1'b0;
    compare_bit("reset_in_ready", in_ready, 1'b1);

    vecs[0] = mk(64'h0000_0000_FFFF_FFFF, 64'h1, OP_ADD, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0);
    vecs[1] = mk('1, 64'h0, OP_ADD, 1'b1, 64'h0, 1'b1, 1'b0, 1'b1);
    vecs[2] = mk(64'h8000_0000_0000_0000, 64'h1, OP_SUB, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
    vecs[3] = mk(64'h5, 64'h3, OP_SUB, 1'b1, 64'h2, 1'b1, 1'b0, 1'b0);
    vecs[4] = mk(64'h3, 64'h5, OP_SUB, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
    vecs[5] = mk(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, OP_ADD, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
    vecs[6] = mk(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, OP_SUB, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1);
    vecs[7] = mk(64'hFFFF, 64'h1, OP_ADD, 1'b1, 64'h1_0001, 1'b0, 1'b0, 1'b0);
    vecs[8] = mk(64'h0000_FFFF_FFFF_FFFF, 64'h1, OP_ADD, 1'b0, 64'h0001_0000_0000_0000, 1'b0, 1'b0, 1'b0);
    vecs[9] = mk(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, OP_ADD, 1'b0, 64'h0, 1'b1, 1'b1, 1'b1);

    for (int i = 0; i < 10; i++) begin
      apply_stimulus(vecs[i], lat);
      check_output($sformatf("vec%0d", i), vecs[i], lat);
    end

    // Back-to-back: results must occupy exactly cycles STAGES .. STAGES+7.
    for (int t = 0; t < 16; t++) begin
      compare_bit($sformatf("stream_valid_c%0d", t), out_valid, (t >= STAGES && t < STAGES + 8));
      if (t < 8) begin
        a        = rand64();
        b        = rand64();
        op       = 1'($urandom_range(0, 1));
        cin      = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    compare_int("stream_drained", exp_q.size(), 0);

    // Backpressure: five stalled cycles under continuous input.
    took = 1'b1;
    for (int t = 0; t < 30; t++) begin
      out_ready = !(t >= 8 && t < 13);
      if (t < 20) begin
        if (took) begin
          a   = rand64();
          b   = rand64();
          op  = 1'($urandom_range(0, 1));
          cin = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (t >= 8 && t < 13) compare_bit($sformatf("bp_in_ready_c%0d", t), in_ready, 1'b0);
      if (t == 13) compare_bit("bp_release_accept", in_ready, 1'b1);
      took = in_valid && in_ready;
      @(posedge clk); #1;
    end
    compare_int("bp_drained", exp_q.size(), 0);

    // Reset mid-flight: three ops in the pipe, plus one presented during reset.
    out_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      a        = rand64();
      b        = rand64();
      op       = 1'($urandom_range(0, 1));
      cin      = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    a   = rand64();
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    compare_bit("midrst_out_valid", out_valid, 1'b0);
    compare_res("midrst_outputs", cur_res(), '0);
    compare_bit("midrst_in_ready", in_ready, 1'b1);
    for (int t = 0; t < 6; t++) begin
      @(posedge clk); #1;
      compare_bit($sformatf("midrst_quiet_c%0d", t), out_valid, 1'b0);
    end
    v.a   = rand64();
    v.b   = rand64();
    v.op  = 1'($urandom_range(0, 1));
    v.cin = 1'($urandom_range(0, 1));
    v.exp = ref_model(v.a, v.b, v.op, v.cin);
    apply_stimulus(v, lat);
    check_output("post_reset", v, lat);

    // Random traffic with random backpressure; the scoreboard does the checking.
    took = 1'b1;
    for (int t = 0; t < 400; t++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (took || !in_valid) begin
        in_valid = ($urandom_range(0, 9) < 7);
        a        = rand64();
        b        = rand64();
        op       = 1'($urandom_range(0, 1));
        cin      = 1'($urandom_range(0, 1));
      end
      #1;
      took = in_valid && in_ready;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (STAGES + 4) @(posedge clk);
    #1;
    compare_int("random_drained", exp_q.size(), 0);
    compare_bit("random_idle", out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
